// File: rtl/down_counter_pkg.sv
// Shared definitions for the down_counter block: FSM encoding and default width.
package down_counter_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with start/stop control, optional auto-reload and a
// registered one-cycle terminal-count pulse.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_nxt;
    logic             tc_nxt;

    // Decrement that holds at zero instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            q          <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_nxt;
            q          <= q_nxt;
            reload_reg <= reload_nxt;
            tc         <= tc_nxt;
        end
    end

    // Priority per edge: load, then stop, then start, then counting.
    always_comb begin
        state_nxt  = state;
        q_nxt      = q;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;
        if (load) begin
            q_nxt      = load_val;
            reload_nxt = load_val;
            state_nxt  = IDLE;
        end else if (stop) begin
            state_nxt = IDLE;
        end else if (start && state == IDLE) begin
            if (q != '0)
                state_nxt = RUN;
        end else if (start && state == DONE) begin
            if (reload_reg != '0) begin
                q_nxt     = reload_reg;
                state_nxt = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    // q == 0 cannot arise in RUN; if it does, finish quietly.
                    if (q == '0) begin
                        state_nxt = DONE;
                    end else if (en) begin
                        if (q == WIDTH'(1)) begin
                            tc_nxt = 1'b1;
                            if (auto_reload) begin
                                q_nxt = reload_reg;
                            end else begin
                                q_nxt     = '0;
                                state_nxt = DONE;
                            end
                        end else begin
                            q_nxt = sat_dec(q);
                        end
                    end
                end
                IDLE, DONE: state_nxt = state;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios plus randomized
// traffic compared each cycle against a behavioural model.
module tb_down_counter;
    import down_counter_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         tc;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: mode 0 = idle, 1 = counting, 2 = finished.
    int m_q;
    int m_rl;
    int m_mode;
    bit m_tc;

    down_counter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .en(en), .auto_reload(auto_reload),
        .q(q), .busy(busy), .done(done), .tc(tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_rl = 0; m_mode = 0; m_tc = 0;
    endtask

    // Applies the rules for one rising edge to the model using current inputs.
    task automatic model_edge();
        m_tc = 0;
        if (load) begin
            m_q = int'(load_val); m_rl = int'(load_val); m_mode = 0;
        end else if (stop) begin
            m_mode = 0;
        end else if (start && m_mode == 0) begin
            if (m_q > 0) m_mode = 1;
        end else if (start && m_mode == 2) begin
            if (m_rl > 0) begin m_q = m_rl; m_mode = 1; end
        end else if (m_mode == 1 && en) begin
            if (m_q == 1) begin
                m_tc = 1;
                if (auto_reload) m_q = m_rl;
                else begin m_q = 0; m_mode = 2; end
            end else begin
                m_q = m_q - 1;
            end
        end
    endtask

    task automatic drive(input bit l, input int lv, input bit st, input bit sp,
                         input bit e, input bit ar);
        load = l; load_val = lv[W-1:0]; start = st; stop = sp; en = e; auto_reload = ar;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("q", q, m_q);
        chk("busy", busy, m_mode == 1);
        chk("done", done, m_mode == 2);
        chk("tc", tc, m_tc);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tc", tc, 0);
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        reset_pulse();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Terminal count: 3,2,1,0 with tc only at 0.
        drive(1, 3, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 1, 0); tick(); chk("t32_q3", q, 3);
        drive(0, 0, 0, 0, 1, 0); tick(); chk("t32_q2", q, 2); chk("t32_tc2", tc, 0);
        tick(); chk("t32_q1", q, 1);
        tick(); chk("t32_q0", q, 0); chk("t32_tc", tc, 1); chk("t32_done", done, 1);
        chk("t32_busy", busy, 0);
        tick(); chk("t32_tc_off", tc, 0);

        // Auto-reload: 2,1,2,1,2 with tc on each return to 2.
        drive(1, 2, 0, 0, 0, 1); tick();
        drive(0, 0, 1, 0, 1, 1); tick(); chk("t33_q2", q, 2);
        drive(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t33_q", q, (i % 2 == 0) ? 1 : 2);
            chk("t33_tc", tc, (i % 2 == 1) ? 1 : 0);
            chk("t33_busy", busy, 1);
        end

        // Pause and resume; en low holds the count.
        drive(1, 6, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick(); chk("t34_hold", q, 6);
        drive(0, 0, 0, 0, 1, 0); tick(); tick(); chk("t34_q4", q, 4);
        drive(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t34_stop_q", q, 4); chk("t34_stop_busy", busy, 0);
        end
        drive(0, 0, 1, 0, 0, 0); tick(); chk("t34_resume_busy", busy, 1);
        drive(0, 0, 0, 0, 1, 0); tick(); chk("t34_q3", q, 3);

        // Priority: load beats stop and start.
        drive(1, 9, 1, 1, 1, 0); tick();
        chk("t35_q", q, 9); chk("t35_busy", busy, 0); chk("t35_done", done, 0);

        // Asynchronous reset between edges.
        drive(1, 5, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0); tick(); tick(); chk("t36_q3", q, 3);
        #2;
        reset_pulse();
        @(posedge clk);
        #1;
        chk("t36_held_q", q, 0);
        reset = 1'b1;

        // Boundaries: start at zero, full-range count, restart from DONE.
        drive(0, 0, 1, 0, 1, 0); tick(); chk("t37_zero_busy", busy, 0);
        drive(1, 15, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt++;
            if (tc) break;
        end
        chk("t37_en_cycles", cnt, 15);
        chk("t37_done", done, 1);
        drive(0, 0, 1, 0, 0, 0); tick();
        chk("t37_restart_q", q, 15); chk("t37_restart_busy", busy, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 11) == 0, $urandom_range(0, 15),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
            tick();
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse();
                #1;
                reset = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, counter width in bits (legal 2..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: load  input  1  synchronous load strobe.
REQ-005 SHALL have port: load_val  input  WIDTH  value for q and reload register.
REQ-006 SHALL have port: start  input  1  start or resume counting.
REQ-007 SHALL have port: stop  input  1  pause counting, hold q.
REQ-008 SHALL have port: en  input  1  count tick qualifier; one decrement per en cycle.
REQ-009 SHALL have port: auto_reload  input  1  reload on terminal count instead of finishing.
REQ-010 SHALL have port: q  output  WIDTH  current count, registered.
REQ-011 SHALL have port: busy  output  1  high while in RUN.
REQ-012 SHALL have port: done  output  1  high while in DONE.
REQ-013 SHALL have port: tc  output  1  one-cycle terminal-count pulse, registered.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; busy and done decoded from the state register only.
REQ-015 SHALL apply per-edge priority: load > stop > start > count.
REQ-016 load (any state): q <= load_val, reload_reg <= load_val, state <= IDLE, tc <= 0.
REQ-017 stop in RUN: state <= IDLE, q held; stop in DONE: state <= IDLE, q held; stop in IDLE: no effect.
REQ-018 start in IDLE with q != 0: state <= RUN at that edge; first decrement no earlier than the next edge with en=1.
REQ-019 start in IDLE with q == 0: ignored, state remains IDLE.
REQ-020 start in DONE with reload_reg != 0: q <= reload_reg, state <= RUN; with reload_reg == 0: ignored.
REQ-021 start in RUN: no effect.
REQ-022 RUN with en=1 and q > 1: q <= q - 1; en=0: q held.
REQ-023 RUN with en=1 and q == 1, auto_reload=0: q <= 0, state <= DONE, tc <= 1 for that cycle.
REQ-024 RUN with en=1 and q == 1, auto_reload=1: q <= reload_reg, state stays RUN, tc <= 1 for that cycle.
REQ-025 tc SHALL be high for exactly one cycle per terminal count and low in every other cycle.
REQ-026 q SHALL never wrap below zero; q == 0 in RUN is unreachable and, if forced, transitions to DONE without tc.
REQ-027 auto_reload SHALL be sampled only at the q == 1 decrement edge; changing it mid-count has no other effect.

Reset
REQ-028 reset low SHALL immediately force q = 0, reload_reg = 0, state = IDLE, busy = 0, done = 0, tc = 0, regardless of clk.
REQ-029 Release of reset SHALL take effect at the first rising clk edge with reset high; no operation is pending after reset.

Structure
REQ-030 SHALL place the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default in shared package down_counter_pkg.
REQ-031 SHALL be one module with no sub-modules; the count register, reload register, FSM and tc register are all in down_counter.

Verification
REQ-032 SHALL check terminal count with WIDTH=4: load 3, start, en=1 held -> q 3,2,1,0 on successive edges, tc=1 only in the cycle q=0, then done=1, busy=0.
REQ-033 SHALL check auto-reload: auto_reload=1, load 2, start, en=1 held -> q 2,1,2,1,... with tc=1 in every cycle where q returns to 2, busy stays 1.
REQ-034 SHALL check pause and resume: load 6, start, decrement to 4, stop for 3 cycles -> q=4, busy=0; start -> q=3 on the next en edge.
REQ-035 SHALL check priority: load=1, load_val=9, start=1, stop=1 on the same edge -> q=9, state IDLE, busy=0.
REQ-036 SHALL check asynchronous reset mid-count: load 5, start, 2 en cycles (q=3), reset low between edges -> q=0, busy=0, tc=0 before the next clk edge.
REQ-037 SHALL check boundaries: start with q=0 -> ignored; load 15, start -> exactly 15 en cycles to tc; start in DONE -> q=15, RUN.
